// File: rtl/trace_video_pkg.sv
// Shared types and constants for the logic-trace video renderer.
package trace_video_pkg;

  // Reference 1280x720 totals; each renderer instance derives its own from its parameters.
  localparam int HTOTAL  = 40 + 220 + 1280 + 110;
  localparam int VTOTAL  = 5 + 20 + 720 + 5;

  // Counter widths cover totals up to 4096 in either direction.
  localparam int H_CNT_W = 12;
  localparam int V_CNT_W = 12;

  typedef logic [H_CNT_W-1:0] hcount_t;
  typedef logic [V_CNT_W-1:0] vcount_t;
  typedef logic [23:0]        rgb_t;

  localparam rgb_t COLOUR_TRACE = 24'hFFFFFF;
  localparam rgb_t COLOUR_BG    = 24'h202020;
  localparam rgb_t COLOUR_GUIDE = 24'h404040;
  localparam rgb_t COLOUR_BLANK = 24'h000000;

  // Per-pixel control that travels alongside the RAM read.
  typedef struct packed {
    logic    hsync;
    logic    vsync;
    logic    de;
    logic    col_ok;    // column holds a displayed sample
    logic    first_px;  // leftmost pixel of its column
    logic    col_nz;    // column index is not zero
    vcount_t row;       // active-area row
  } pix_ctl_t;

  // Final colour priority: blanking, trace, baseline guide, background.
  function automatic rgb_t pick_colour(input logic de, input logic trace, input logic guide);
    if (!de)   return COLOUR_BLANK;
    if (trace) return COLOUR_TRACE;
    if (guide) return COLOUR_GUIDE;
    return COLOUR_BG;
  endfunction

endpackage

// File: rtl/trace_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read of the slot being written in the same cycle returns the old contents.
module trace_sample_ram #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write and read in one process so a colliding read sees the pre-write value
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/logic_trace_renderer.sv
// Captures CHANNELS logic levels into a circular buffer and renders them as
// logic-analyser lanes inside a parametrised video timing frame.
module logic_trace_renderer
  import trace_video_pkg::*;
#(
  parameter int HSYNC          = 40,
  parameter int HBACK          = 220,
  parameter int HACTIVE        = 1280,
  parameter int HFRONT         = 110,
  parameter int VSYNC          = 5,
  parameter int VBACK          = 20,
  parameter int VACTIVE        = 720,
  parameter int VFRONT         = 5,
  parameter int CHANNELS       = 4,
  parameter int DEPTH          = 256,
  parameter int PIX_PER_SAMPLE = 4,
  parameter int LANE_TOP       = 100,
  parameter int LANE_PITCH     = 100,
  parameter int TRACE_HEIGHT   = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [CHANNELS-1:0] sample_data,
  input  logic                freeze,
  output logic [23:0]         video_data,
  output logic                video_de,
  output logic                video_hsync,
  output logic                video_vsync
);

  localparam int      AW        = $clog2(DEPTH);
  localparam int      PIX_SHIFT = $clog2(PIX_PER_SAMPLE);
  localparam hcount_t H_LAST    = hcount_t'(HSYNC + HBACK + HACTIVE + HFRONT - 1);
  localparam vcount_t V_LAST    = vcount_t'(VSYNC + VBACK + VACTIVE + VFRONT - 1);
  localparam hcount_t H_SYNC_E  = hcount_t'(HSYNC);
  localparam vcount_t V_SYNC_E  = vcount_t'(VSYNC);
  localparam hcount_t H_ACT0    = hcount_t'(HSYNC + HBACK);
  localparam vcount_t V_ACT0    = vcount_t'(VSYNC + VBACK);
  localparam hcount_t H_ACT_E   = hcount_t'(HSYNC + HBACK + HACTIVE);
  localparam vcount_t V_ACT_E   = vcount_t'(VSYNC + VBACK + VACTIVE);
  localparam hcount_t PIX_MASK  = hcount_t'(PIX_PER_SAMPLE - 1);
  localparam hcount_t DEPTH_H   = hcount_t'(DEPTH);
  localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (v == FILL_FULL) ? v : v + (AW+1)'(1);
  endfunction

  function automatic vcount_t lane_top(input int c);
    return vcount_t'(LANE_TOP + c * LANE_PITCH);
  endfunction

  function automatic vcount_t lane_bot(input int c);
    return vcount_t'(LANE_TOP + c * LANE_PITCH + TRACE_HEIGHT);
  endfunction

  hcount_t             hcount_q, hcount_d;
  vcount_t             vcount_q, vcount_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       base_q, base_d;
  logic [AW:0]         fill_q, fill_d;
  logic [AW:0]         shown_q, shown_d;
  logic                wr_en;
  hcount_t             x, column;
  vcount_t             y;
  logic [AW-1:0]       rd_addr_p1_q, rd_addr_p1_d;
  pix_ctl_t            ctl_p1_q, ctl_p1_d, ctl_p2_q;
  logic [CHANNELS-1:0] rd_data_p2;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic                trace_hit, guide_hit;
  rgb_t                video_data_q, video_data_d;
  logic                de_q, hsync_q, vsync_q;

  // Stage 0: timing counters, capture bookkeeping and the once-per-frame display window
  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + hcount_t'(1);
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + vcount_t'(1);
    wr_en    = sample_valid && !freeze;
    wr_ptr_d = wr_en ? wr_ptr_q + (AW)'(1) : wr_ptr_q;
    fill_d   = wr_en ? sat_inc(fill_q) : fill_q;
    base_d   = base_q;
    shown_d  = shown_q;
    if (hcount_q == '0 && vcount_q == '0) begin
      // Once the buffer has wrapped, the oldest sample sits at the write pointer.
      base_d  = (fill_q == FILL_FULL) ? wr_ptr_q : '0;
      shown_d = fill_q;
    end
  end

  // Stage 1: active-area coordinates, sample column and buffer read address
  always_comb begin
    x                 = hcount_q - H_ACT0;
    y                 = vcount_q - V_ACT0;
    column            = x >> PIX_SHIFT;
    ctl_p1_d.hsync    = hcount_q < H_SYNC_E;
    ctl_p1_d.vsync    = vcount_q < V_SYNC_E;
    ctl_p1_d.de       = (hcount_q >= H_ACT0) && (hcount_q < H_ACT_E) &&
                        (vcount_q >= V_ACT0) && (vcount_q < V_ACT_E);
    ctl_p1_d.col_ok   = (column < hcount_t'(shown_q)) && (column < DEPTH_H);
    ctl_p1_d.first_px = (x & PIX_MASK) == '0;
    ctl_p1_d.col_nz   = column != '0;
    ctl_p1_d.row      = y;
    rd_addr_p1_d      = base_q + column[AW-1:0];
  end

  trace_sample_ram #(
    .WIDTH (CHANNELS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (sample_data),
    .rd_addr (rd_addr_p1_q),
    .rd_data (rd_data_p2)
  );

  // Stage 2: compose the pixel from the sample bits and the previous column's bits
  always_comb begin
    trace_hit = 1'b0;
    guide_hit = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ctl_p2_q.col_ok) begin
        if (rd_data_p2[c] && ctl_p2_q.row == lane_top(c))  trace_hit = 1'b1;
        if (!rd_data_p2[c] && ctl_p2_q.row == lane_bot(c)) trace_hit = 1'b1;
        if (ctl_p2_q.first_px && ctl_p2_q.col_nz && (rd_data_p2[c] != prev_q[c]) &&
            ctl_p2_q.row >= lane_top(c) && ctl_p2_q.row <= lane_bot(c)) trace_hit = 1'b1;
      end
      if (ctl_p2_q.row == lane_bot(c)) guide_hit = 1'b1;
    end
    video_data_d = pick_colour(ctl_p2_q.de, trace_hit, guide_hit);
    prev_d       = ctl_p2_q.first_px ? rd_data_p2 : prev_q;
  end

  // Control and output registers: cleared by reset so the frame restarts cleanly
  always_ff @(posedge clock) begin
    if (reset) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      base_q       <= '0;
      shown_q      <= '0;
      ctl_p1_q     <= '0;
      ctl_p2_q     <= '0;
      video_data_q <= '0;
      de_q         <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      base_q       <= base_d;
      shown_q      <= shown_d;
      ctl_p1_q     <= ctl_p1_d;
      ctl_p2_q     <= ctl_p1_q;
      video_data_q <= video_data_d;
      de_q         <= ctl_p2_q.de;
      hsync_q      <= ctl_p2_q.hsync;
      vsync_q      <= ctl_p2_q.vsync;
    end
  end

  // Datapath registers; everything they feed is qualified by reset-cleared control
  always_ff @(posedge clock) begin
    rd_addr_p1_q <= rd_addr_p1_d;
    prev_q       <= prev_d;
  end

  assign video_data  = video_data_q;
  assign video_de    = de_q;
  assign video_hsync = hsync_q;
  assign video_vsync = vsync_q;

endmodule

// File: tb/tb_logic_trace_renderer.sv
// Directed bench for logic_trace_renderer using a reduced video timing.
module tb_logic_trace_renderer;

  localparam int HSYNC = 2, HBACK = 3, HACTIVE = 64, HFRONT = 3;
  localparam int VSYNC = 1, VBACK = 2, VACTIVE = 40, VFRONT = 1;
  localparam int HT = HSYNC + HBACK + HACTIVE + HFRONT;
  localparam int VT = VSYNC + VBACK + VACTIVE + VFRONT;
  localparam int FRAME = HT * VT;
  localparam int H0 = HSYNC + HBACK;
  localparam int V0 = VSYNC + VBACK;
  localparam logic [23:0] WHITE = 24'hFFFFFF, BG = 24'h202020, GUIDE = 24'h404040;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [3:0]  sample_data = 4'h0;
  logic        freeze = 1'b0;
  logic [23:0] video_data;
  logic        video_de, video_hsync, video_vsync;

  always #5 clock = ~clock;

  logic_trace_renderer #(
    .HSYNC(HSYNC), .HBACK(HBACK), .HACTIVE(HACTIVE), .HFRONT(HFRONT),
    .VSYNC(VSYNC), .VBACK(VBACK), .VACTIVE(VACTIVE), .VFRONT(VFRONT),
    .CHANNELS(4), .DEPTH(16), .PIX_PER_SAMPLE(4),
    .LANE_TOP(2), .LANE_PITCH(9), .TRACE_HEIGHT(6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .freeze       (freeze),
    .video_data   (video_data),
    .video_de     (video_de),
    .video_hsync  (video_hsync),
    .video_vsync  (video_vsync)
  );

  int checks = 0;
  int errors = 0;
  int pos = 0;   // counter state index since the last reset edge
  int hs_cnt, vs_cnt, de_cnt;
  logic [23:0] fb     [VACTIVE][HACTIVE];
  logic [23:0] fb_ref [VACTIVE][HACTIVE];

  typedef struct {
    string       name;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    pos++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    pos   = 0;
    reset = 1'b0;
  endtask

  // mode 0: channel 0 alternates starting high; mode 1: value = index[3:0]
  task automatic inject(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (pos % FRAME == 0) tick();
      sample_data  = (mode == 0) ? {3'b000, ~i[0]} : i[3:0];
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
    end
  endtask

  // Record one whole frame, checking sync/enable against a counter model 3 cycles behind.
  task automatic watch_frame();
    int p, h, v, bad;
    logic ehs, evs, ede;
    do tick(); while (pos < 3 || (pos - 3) % FRAME != 0);
    bad = 0; hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    for (int n = 0; n < FRAME; n++) begin
      if (n != 0) tick();
      p   = pos - 3;
      h   = p % HT;
      v   = (p / HT) % VT;
      ehs = (h < HSYNC);
      evs = (v < VSYNC);
      ede = (h >= H0) && (h < H0 + HACTIVE) && (v >= V0) && (v < V0 + VACTIVE);
      if (video_hsync !== ehs || video_vsync !== evs || video_de !== ede) bad++;
      if (!ede && video_data !== 24'h0) bad++;
      if (ede) fb[v - V0][h - H0] = video_data;
      hs_cnt += int'(video_hsync);
      vs_cnt += int'(video_vsync);
      de_cnt += int'(video_de);
    end
    chk("frame_timing_bad_cycles", bad, 0);
  endtask

  task automatic add(input string name, input int x, input int y, input logic [23:0] rgb);
    vec_t e;
    e.name = name; e.x = x; e.y = y; e.rgb = rgb;
    tbl.push_back(e);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++)
      chk({tag, "_", tbl[i].name}, {8'h0, fb[tbl[i].y][tbl[i].x]}, {8'h0, tbl[i].rgb});
    tbl.delete();
  endtask

  function automatic int count_rgb(input logic [23:0] rgb);
    int n = 0;
    for (int yy = 0; yy < VACTIVE; yy++)
      for (int xx = 0; xx < HACTIVE; xx++)
        if (fb[yy][xx] == rgb) n++;
    return n;
  endfunction

  function automatic int diff_ref();
    int n = 0;
    for (int yy = 0; yy < VACTIVE; yy++)
      for (int xx = 0; xx < HACTIVE; xx++)
        if (fb[yy][xx] !== fb_ref[yy][xx]) n++;
    return n;
  endfunction

  initial begin
    // Reset and an empty frame
    do_reset(3);
    chk("reset_outputs", {4'h0, video_data, video_de, video_hsync, video_vsync}, 32'h0);
    watch_frame();
    chk("s1_hsync_cycles", hs_cnt, HSYNC * VT);
    chk("s1_vsync_cycles", vs_cnt, VSYNC * HT);
    chk("s1_de_cycles", de_cnt, HACTIVE * VACTIVE);
    chk("s1_white_pixels", count_rgb(WHITE), 0);
    chk("s1_guide_pixels", count_rgb(GUIDE), 4 * HACTIVE);
    chk("s1_bg_pixels", count_rgb(BG), HACTIVE * VACTIVE - 4 * HACTIVE);
    add("lane0_guide", 0, 8, GUIDE);    add("lane0_guide_mid", 10, 8, GUIDE);
    add("lane0_top", 0, 2, BG);         add("row0", 5, 0, BG);
    add("lane3_guide", 0, 35, GUIDE);   add("corner", 63, 39, BG);
    run_table("s1");

    // Channel 0 toggling for 10 samples
    inject(10, 0);
    watch_frame();
    chk("s2_white_total", count_rgb(WHITE), 214);
    add("c0_top", 0, 2, WHITE);         add("c0_no_edge", 0, 5, BG);
    add("c0_guide", 0, 8, GUIDE);       add("c1_edge", 4, 5, WHITE);
    add("c1_inner", 5, 5, BG);          add("c1_low", 5, 8, WHITE);
    add("c1_top", 5, 2, BG);            add("c2_edge", 8, 5, WHITE);
    add("c2_guide", 9, 8, GUIDE);       add("c9_edge", 36, 5, WHITE);
    add("c9_low", 37, 8, WHITE);        add("c10_mid", 40, 5, BG);
    add("c10_guide", 40, 8, GUIDE);     add("lane1_low", 0, 17, WHITE);
    add("lane1_c10", 40, 17, GUIDE);    add("lane1_noedge", 4, 14, BG);
    run_table("s2");

    // A sample on the latch cycle appears one frame later
    while (pos % FRAME != 0) tick();
    sample_data = 4'b0001; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    watch_frame();
    add("excl_top", 41, 2, BG);         add("excl_guide", 41, 8, GUIDE);
    run_table("latch0");
    watch_frame();
    add("incl_top", 41, 2, WHITE);      add("incl_edge", 40, 5, WHITE);
    run_table("latch1");

    // Wrap: 20 samples into depth 16, column c shows sample 4+c
    do_reset(1);
    inject(20, 1);
    watch_frame();
    add("c0_l0_low", 1, 8, WHITE);      add("c0_l2_high", 1, 20, WHITE);
    add("c0_l0_top", 1, 2, BG);         add("c15_l0_high", 61, 2, WHITE);
    add("c15_l1_high", 61, 11, WHITE);  add("c15_l2_low", 61, 26, WHITE);
    add("c15_l3_low", 61, 35, WHITE);   add("c12_l0_edge", 48, 5, WHITE);
    add("c12_l3_edge", 48, 32, WHITE);  add("c12_inner", 49, 5, BG);
    add("c15_l0_edge", 60, 5, WHITE);   add("c15_l1_noedge", 60, 14, BG);
    run_table("s3");

    // Freeze: discarded samples leave the display untouched
    fb_ref = fb;
    freeze = 1'b1;
    inject(50, 0);
    watch_frame();
    chk("freeze_frame1_diff", diff_ref(), 0);
    watch_frame();
    chk("freeze_frame2_diff", diff_ref(), 0);
    freeze = 1'b0;

    // Reset in the middle of a frame
    while (pos % FRAME != 20 * HT + 10) tick();
    reset = 1'b1;
    tick();
    pos = 0;
    chk("midreset_outputs", {4'h0, video_data, video_de, video_hsync, video_vsync}, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    chk("midreset_flush", {4'h0, video_data, video_de, video_hsync, video_vsync}, 32'h0);
    watch_frame();
    chk("s5_white_pixels", count_rgb(WHITE), 0);
    add("lane0_guide", 0, 8, GUIDE);    add("lane0_top", 0, 2, BG);
    run_table("s5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
